// File: rtl/l1_abs_sum_stage.sv
// L1-norm feeder: buffers one signed vector while summing |x|, then replays it with the norm.
// Optional: define L1_SUM_ZERO_GUARD_EN to add zero_norm and force an all-zero norm to 1.
module l1_abs_sum_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned CNT_W   = $clog2(VEC_LEN),
    parameter int unsigned SUM_W   = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] input_data,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] output_data,
    output logic [SUM_W-1:0]  norm_out,
    output logic              last_out
`ifdef L1_SUM_ZERO_GUARD_EN
    ,
    output logic              zero_norm
`endif
);

    typedef enum logic {StAccum, StDrain} state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_idx;
    logic [SUM_W-1:0]  r_acc;
    logic [SUM_W-1:0]  r_norm;
    logic [DATA_W-1:0] r_buf [VEC_LEN];

    logic [DATA_W-1:0] w_abs;
    logic [SUM_W-1:0]  w_sum;
    logic              w_accept;
    logic              w_xfer;
    logic              w_idx_last;

    // Two's-complement negate in DATA_W bits; the most negative value lands on 2^(DATA_W-1).
    assign w_abs      = input_data[DATA_W-1] ? (~input_data + DATA_W'(1)) : input_data;
    assign w_sum      = r_acc + SUM_W'(w_abs);
    assign w_idx_last = (r_idx == CNT_W'(VEC_LEN - 1));
    assign w_accept   = valid_in && ready_in;
    assign w_xfer     = valid_out && ready_out;

    assign ready_in    = (r_state == StAccum);
    assign valid_out   = (r_state == StDrain);
    assign output_data = valid_out ? r_buf[r_idx] : '0;
    assign norm_out    = valid_out ? r_norm : '0;
    assign last_out    = valid_out && w_idx_last;

`ifdef L1_SUM_ZERO_GUARD_EN
    logic r_zero;
    assign zero_norm = valid_out && r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StAccum;
            r_idx   <= '0;
            r_acc   <= '0;
            r_norm  <= '0;
`ifdef L1_SUM_ZERO_GUARD_EN
            r_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                StAccum: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= StDrain;
`ifdef L1_SUM_ZERO_GUARD_EN
                            r_norm  <= (w_sum == '0) ? SUM_W'(1) : w_sum;
                            r_zero  <= (w_sum == '0);
`else
                            r_norm  <= w_sum;
`endif
                        end else begin
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_xfer) begin
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_acc   <= '0;
                            r_state <= StAccum;
                        end else begin
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Buffer needs no reset: its contents are only visible while draining a complete vector.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_idx] <= input_data;
        end
    end

endmodule
